// File: rtl/dcs_clk_monitor.sv
// Measures the DCS output (through an external divide-by-4) over a fixed clk_50m gate window
// and reports which PLL input it matches, plus mismatch/dead/unknown flags.
module dcs_clk_monitor #(
  parameter int GATE_CYCLES = 50000,
  parameter int CNT_W       = 16,
  parameter int EXP0        = 6250,
  parameter int EXP1        = 5488,
  parameter int EXP2        = 5000,
  parameter int EXP3        = 3750,
  parameter int TOL         = 20
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic             enable,
  input  logic             meas_in,
  input  logic [3:0]       clksel_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             count_valid,
  output logic [1:0]       sel_idx,
  output logic             sel_match,
  output logic             unknown,
  output logic             dead,
  output logic             busy
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic signed [CNT_W:0] TOL_P = (CNT_W+1)'(TOL);
  localparam logic signed [CNT_W:0] TOL_N = -TOL_P;
  localparam logic [CNT_W-1:0] EXP_TAB [4] = '{CNT_W'(EXP0), CNT_W'(EXP1), CNT_W'(EXP2), CNT_W'(EXP3)};

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, REPORT} state_t;

  state_t            state_reg, state_next;
  logic              sync1_reg, sync2_reg, sync3_reg;
  logic              meas_edge;
  logic [GATE_W-1:0] gate_cnt_reg;
  logic [CNT_W-1:0]  edge_cnt_reg;
  logic              ovf_reg;
  logic [3:0]        sel_q_reg;
  logic              clear_cnt, capture_sel, do_report;
  logic              gate_last, sel_changed;

  logic [CNT_W-1:0]  freq_count_reg;
  logic              count_valid_reg;
  logic [1:0]        sel_idx_reg;
  logic              sel_match_reg, unknown_reg, dead_reg;

  logic [3:0]        hit;
  logic              any_hit;
  logic [1:0]        match_idx;
  logic              sel_onehot;
  logic              cls_dead, cls_unknown, cls_match;
  logic [1:0]        cls_idx;

  // Two flops for metastability, the third only for rising-edge detection.
  always_ff @(posedge clk_50m) begin
    if (!rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
    end else begin
      sync1_reg <= meas_in;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  assign meas_edge   = sync2_reg & ~sync3_reg;
  assign gate_last   = (gate_cnt_reg == GATE_LAST);
  assign sel_changed = (clksel_in != sel_q_reg);

  always_ff @(posedge clk_50m) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    clear_cnt   = 1'b0;
    capture_sel = 1'b0;
    do_report   = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      clear_cnt  = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next  = SETTLE;
          capture_sel = 1'b1;
          clear_cnt   = 1'b1;
        end
        SETTLE: begin
          if (sel_changed) begin
            capture_sel = 1'b1;
            clear_cnt   = 1'b1;
          end else if (gate_last) begin
            state_next = MEASURE;
            clear_cnt  = 1'b1;
          end
        end
        MEASURE: begin
          // A select change on the terminal cycle aborts rather than reports.
          if (sel_changed) begin
            state_next  = SETTLE;
            capture_sel = 1'b1;
            clear_cnt   = 1'b1;
          end else if (gate_last) begin
            state_next = REPORT;
          end
        end
        REPORT: begin
          do_report  = 1'b1;
          clear_cnt  = 1'b1;
          state_next = MEASURE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50m) begin
    if (!rst) begin
      gate_cnt_reg <= '0;
      edge_cnt_reg <= '0;
      ovf_reg      <= 1'b0;
    end else if (clear_cnt) begin
      gate_cnt_reg <= '0;
      edge_cnt_reg <= '0;
      ovf_reg      <= 1'b0;
    end else if (state_reg == SETTLE || state_reg == MEASURE) begin
      gate_cnt_reg <= gate_cnt_reg + 1'b1;
      if (state_reg == MEASURE && meas_edge) begin
        if (edge_cnt_reg == CNT_MAX) ovf_reg      <= 1'b1;
        else                         edge_cnt_reg <= edge_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (!rst)             sel_q_reg <= '0;
    else if (capture_sel) sel_q_reg <= clksel_in;
  end

  // Signed CNT_W+1 difference so counts below EXPn do not wrap.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cls
    logic signed [CNT_W:0] diff;
    assign diff    = $signed({1'b0, edge_cnt_reg}) - $signed({1'b0, EXP_TAB[gi]});
    assign hit[gi] = (diff <= TOL_P) && (diff >= TOL_N);
  end

  always_comb begin
    any_hit   = 1'b0;
    match_idx = 2'd0;
    for (int n = 3; n >= 0; n--) begin
      if (hit[n]) begin
        any_hit   = 1'b1;
        match_idx = 2'(n);
      end
    end
  end

  assign sel_onehot  = (sel_q_reg != 4'd0) && ((sel_q_reg & (sel_q_reg - 4'd1)) == 4'd0);
  assign cls_dead    = (edge_cnt_reg == '0);
  assign cls_unknown = ovf_reg | ~any_hit | cls_dead;
  assign cls_idx     = cls_unknown ? 2'd0 : match_idx;
  assign cls_match   = ~cls_unknown & sel_onehot & sel_q_reg[cls_idx];

  always_ff @(posedge clk_50m) begin
    if (!rst) begin
      freq_count_reg  <= '0;
      count_valid_reg <= 1'b0;
      sel_idx_reg     <= 2'd0;
      sel_match_reg   <= 1'b0;
      unknown_reg     <= 1'b0;
      dead_reg        <= 1'b0;
    end else begin
      count_valid_reg <= do_report;
      if (do_report) begin
        freq_count_reg <= edge_cnt_reg;
        sel_idx_reg    <= cls_idx;
        sel_match_reg  <= cls_match;
        unknown_reg    <= cls_unknown;
        dead_reg       <= cls_dead;
      end
    end
  end

  assign freq_count  = freq_count_reg;
  assign count_valid = count_valid_reg;
  assign sel_idx     = sel_idx_reg;
  assign sel_match   = sel_match_reg;
  assign unknown     = unknown_reg;
  assign dead        = dead_reg;
  assign busy        = (state_reg != IDLE);

endmodule
